// File: rtl/soc_addr_map_unit.sv
// soc_addr_map_unit: configurable address decoder with register-mapped rules and a one-entry result register
module soc_addr_map_unit #(
  parameter int NumRules = 14,
  parameter int AddrWidth = 64,
  parameter logic [NumRules*AddrWidth-1:0] ResetStart = '0,
  parameter logic [NumRules*AddrWidth-1:0] ResetEnd = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [6:0]           cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lk_valid_i,
  output logic                 lk_ready_o,
  input  logic [AddrWidth-1:0] lk_addr_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [4:0]           res_idx_o,
  output logic                 res_hit_o,
  output logic                 res_decerr_o
);
  logic lock, def_en, mapped, wr, hit;
  logic [4:0] def_idx, hidx;
  logic [5:0] ridx;
  logic [NumRules-1:0] rule_en;
  logic [AddrWidth-1:0] rs [NumRules];
  logic [AddrWidth-1:0] re [NumRules];
  logic [AddrWidth-1:0] rd;
  assign cfg_gnt_o = cfg_req_i;
  assign lk_ready_o = !res_valid_o || res_ready_i;
  assign wr = cfg_req_i && cfg_we_i && !lock && mapped;
  always_comb begin
    ridx = cfg_addr_i[6:1] - 6'd2;
    mapped = cfg_addr_i <= 7'd2 || (cfg_addr_i >= 7'd4 && {1'b0, cfg_addr_i} < 8'(4 + 2 * NumRules));
    rd = cfg_addr_i == 7'd0 ? AddrWidth'({def_en, lock}) :
         cfg_addr_i == 7'd1 ? AddrWidth'(def_idx) :
         cfg_addr_i == 7'd2 ? AddrWidth'(rule_en) : '0;
    for (int i = 0; i < NumRules; i++)
      if (cfg_addr_i >= 7'd4 && ridx == 6'(i)) rd = cfg_addr_i[0] ? re[i] : rs[i];
    hit = 1'b0;
    hidx = '0;
    for (int i = NumRules - 1; i >= 0; i--)
      if (rule_en[i] && lk_addr_i >= rs[i] && lk_addr_i < re[i]) begin
        hit = 1'b1;
        hidx = 5'(i);
      end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock <= 1'b0;
      def_en <= 1'b0;
      def_idx <= '0;
      rule_en <= '1;
      for (int i = 0; i < NumRules; i++) begin
        rs[i] <= ResetStart[i*AddrWidth +: AddrWidth];
        re[i] <= ResetEnd[i*AddrWidth +: AddrWidth];
      end
    end else if (wr) begin
      if (cfg_addr_i == 7'd0) begin
        lock <= lock | cfg_wdata_i[0];
        def_en <= cfg_wdata_i[1];
      end
      if (cfg_addr_i == 7'd1) def_idx <= cfg_wdata_i[4:0];
      if (cfg_addr_i == 7'd2) rule_en <= cfg_wdata_i[NumRules-1:0];
      for (int i = 0; i < NumRules; i++)
        if (cfg_addr_i >= 7'd4 && ridx == 6'(i)) begin
          if (cfg_addr_i[0]) re[i] <= cfg_wdata_i;
          else rs[i] <= cfg_wdata_i;
        end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o <= '0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_rdata_o <= cfg_req_i && !cfg_we_i && mapped ? rd : '0;
      cfg_err_o <= cfg_req_i && (!mapped || (cfg_we_i && lock));
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o <= 1'b0;
      res_idx_o <= '0;
      res_hit_o <= 1'b0;
      res_decerr_o <= 1'b0;
    end else if (lk_valid_i && lk_ready_o) begin
      res_valid_o <= 1'b1;
      res_idx_o <= hit ? hidx : def_en ? def_idx : 5'd0;
      res_hit_o <= hit;
      res_decerr_o <= !hit && !def_en;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_soc_addr_map_unit.sv
// tb_soc_addr_map_unit: directed self-checking bench for soc_addr_map_unit
module tb_soc_addr_map_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_req = 1'b0, cfg_we = 1'b0;
  logic [6:0] cfg_addr = '0;
  logic [63:0] cfg_wdata = '0;
  logic cfg_gnt, cfg_rvalid, cfg_err;
  logic [63:0] cfg_rdata;
  logic lk_valid = 1'b0, lk_ready;
  logic [63:0] lk_addr = '0;
  logic res_valid, res_ready = 1'b1, res_hit, res_decerr;
  logic [4:0] res_idx;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  soc_addr_map_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_idx_o(res_idx),
    .res_hit_o(res_hit), .res_decerr_o(res_decerr)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic res(input string tag, input logic v, input logic [4:0] idx, input logic h, input logic de);
    chk({tag, ".valid"}, 64'(res_valid), 64'(v));
    chk({tag, ".idx"}, 64'(res_idx), 64'(idx));
    chk({tag, ".hit"}, 64'(res_hit), 64'(h));
    chk({tag, ".decerr"}, 64'(res_decerr), 64'(de));
  endtask
  task automatic cfg_wr(input string tag, input logic [6:0] a, input logic [63:0] d, input logic e);
    cfg_req = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    #1 chk({tag, ".gnt"}, 64'(cfg_gnt), 64'd1);
    @(posedge clk);
    #1 cfg_req = 1'b0;
    cfg_we = 1'b0;
    chk({tag, ".rvalid"}, 64'(cfg_rvalid), 64'd1);
    chk({tag, ".err"}, 64'(cfg_err), 64'(e));
  endtask
  task automatic cfg_rd(input string tag, input logic [6:0] a, input logic [63:0] d, input logic e);
    cfg_req = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = a;
    @(posedge clk);
    #1 cfg_req = 1'b0;
    chk({tag, ".rvalid"}, 64'(cfg_rvalid), 64'd1);
    chk({tag, ".rdata"}, cfg_rdata, d);
    chk({tag, ".err"}, 64'(cfg_err), 64'(e));
    @(posedge clk);
    #1 chk({tag, ".rvalid_drop"}, 64'(cfg_rvalid), 64'd0);
  endtask
  task automatic lk(input logic [63:0] a);
    lk_valid = 1'b1;
    lk_addr = a;
    @(posedge clk);
    #1 lk_valid = 1'b0;
  endtask
  initial begin
    #12;
    res("reset", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("reset.cfg_rvalid", 64'(cfg_rvalid), 64'd0);
    chk("reset.cfg_rdata", cfg_rdata, 64'd0);
    chk("reset.lk_ready", 64'(lk_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_rd("rd_rule_en", 7'd2, 64'h3FFF, 1'b0);
    cfg_rd("rd_word3", 7'd3, 64'd0, 1'b1);
    cfg_rd("rd_word32", 7'd32, 64'd0, 1'b1);
    cfg_rd("rd_end13", 7'd31, 64'd0, 1'b0);
    cfg_wr("wr_s0", 7'd4, 64'h1000, 1'b0);
    cfg_wr("wr_e0", 7'd5, 64'h2000, 1'b0);
    cfg_wr("wr_s1", 7'd6, 64'h1800, 1'b0);
    cfg_wr("wr_e1", 7'd7, 64'h3000, 1'b0);
    cfg_wr("wr_def", 7'd1, 64'hFFED, 1'b0);
    cfg_rd("rd_def", 7'd1, 64'd13, 1'b0);
    cfg_rd("rd_s0", 7'd4, 64'h1000, 1'b0);
    cfg_wr("wr_unmapped", 7'd40, 64'h1234, 1'b1);
    lk(64'h1800);
    res("lk1800", 1'b1, 5'd0, 1'b1, 1'b0);
    lk(64'h2FFF);
    res("lk2fff", 1'b1, 5'd1, 1'b1, 1'b0);
    lk(64'h3000);
    res("lk3000_nodef", 1'b1, 5'd0, 1'b0, 1'b1);
    lk(64'h0FFF);
    res("lk0fff_nodef", 1'b1, 5'd0, 1'b0, 1'b1);
    cfg_wr("wr_ctrl_def", 7'd0, 64'd2, 1'b0);
    lk(64'h3000);
    res("lk3000_def", 1'b1, 5'd13, 1'b0, 1'b0);
    cfg_rd("rd_ctrl", 7'd0, 64'd2, 1'b0);
    lk_valid = 1'b1;
    lk_addr = 64'h1000;
    @(posedge clk);
    #1 res("b2b_a", 1'b1, 5'd0, 1'b1, 1'b0);
    lk_addr = 64'h2000;
    @(posedge clk);
    #1 res("b2b_b", 1'b1, 5'd1, 1'b1, 1'b0);
    lk_valid = 1'b0;
    @(posedge clk);
    #1 chk("drain.valid", 64'(res_valid), 64'd0);
    cfg_wr("wr_en", 7'd2, 64'h3FFE, 1'b0);
    lk(64'h1800);
    res("lk_r0_off", 1'b1, 5'd1, 1'b1, 1'b0);
    cfg_wr("wr_en_all", 7'd2, 64'h3FFF, 1'b0);
    res_ready = 1'b0;
    lk(64'h1000);
    res("stall0", 1'b1, 5'd0, 1'b1, 1'b0);
    lk_valid = 1'b1;
    lk_addr = 64'h2FFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 res("stall", 1'b1, 5'd0, 1'b1, 1'b0);
      chk("stall.lk_ready", 64'(lk_ready), 64'd0);
    end
    res_ready = 1'b1;
    #1 chk("release.lk_ready", 64'(lk_ready), 64'd1);
    @(posedge clk);
    #1 lk_valid = 1'b0;
    res("release", 1'b1, 5'd1, 1'b1, 1'b0);
    lk_valid = 1'b1;
    lk_addr = 64'h1800;
    cfg_wr("wr_e0_same", 7'd5, 64'h1000, 1'b0);
    lk_valid = 1'b0;
    res("same_cycle", 1'b1, 5'd0, 1'b1, 1'b0);
    lk(64'h1800);
    res("after_write", 1'b1, 5'd1, 1'b1, 1'b0);
    cfg_wr("wr_lock", 7'd0, 64'd1, 1'b0);
    cfg_wr("wr_locked_s0", 7'd4, 64'h5000, 1'b1);
    cfg_rd("rd_locked_s0", 7'd4, 64'h1000, 1'b0);
    cfg_wr("wr_ctrl0", 7'd0, 64'd0, 1'b1);
    cfg_rd("rd_ctrl_lock", 7'd0, 64'd1, 1'b0);
    res_ready = 1'b0;
    lk(64'h1800);
    res("pre_rst", 1'b1, 5'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 res("async_rst", 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    cfg_rd("post_ctrl", 7'd0, 64'd0, 1'b0);
    cfg_rd("post_s0", 7'd4, 64'd0, 1'b0);
    cfg_rd("post_e1", 7'd7, 64'd0, 1'b0);
    cfg_rd("post_en", 7'd2, 64'h3FFF, 1'b0);
    cfg_rd("post_def", 7'd1, 64'd0, 1'b0);
    lk(64'h1800);
    res("post_lk", 1'b1, 5'd0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/soc_addr_map_unit.md
SOC_ADDR_MAP_UNIT -- requirements
Module: soc_addr_map_unit

Interface
REQ-001 SHALL have parameter NumRules, default 14, number of address rules (1..32).
REQ-002 SHALL have parameter AddrWidth, default 64, lookup and rule address width.
REQ-003 SHALL have parameter ResetStart, default all-zero, NumRules x AddrWidth packed array of reset start addresses.
REQ-004 SHALL have parameter ResetEnd, default all-zero, NumRules x AddrWidth packed array of reset end addresses (exclusive).
REQ-005 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: cfg_req_i  in  1  config request; cfg_we_i  in  1  write enable; cfg_addr_i  in  7  word index; cfg_wdata_i  in  AddrWidth  write data.
REQ-007 SHALL have ports: cfg_gnt_o  out  1  grant; cfg_rvalid_o  out  1  response valid; cfg_rdata_o  out  AddrWidth  read data; cfg_err_o  out  1  response error.
REQ-008 SHALL have ports: lk_valid_i  in  1; lk_ready_o  out  1; lk_addr_i  in  AddrWidth  address to decode.
REQ-009 SHALL have ports: res_valid_o  out  1; res_ready_i  in  1; res_idx_o  out  5  selected rule/default index; res_hit_o  out  1  rule matched; res_decerr_o  out  1  no rule and no default.

Function
REQ-010 SHALL map config words: 0 CTRL (bit0 LOCK, bit1 DEF_EN); 1 DEF_IDX (bits 4:0); 2 RULE_EN (bit i enables rule i); 4+2i START[i]; 5+2i END[i].
REQ-011 SHALL assert cfg_gnt_o combinationally equal to cfg_req_i (always accept).
REQ-012 SHALL assert cfg_rvalid_o exactly one cycle after each granted request, with cfg_rdata_o/cfg_err_o valid in that cycle only.
REQ-013 SHALL return register contents on reads; reads of unmapped words (3, or >= 4+2*NumRules) SHALL return 0 with cfg_err_o=1.
REQ-014 SHALL apply writes at the granting edge; written value visible to lookups from the next cycle.
REQ-015 SHALL, while LOCK=1, ignore all writes and respond cfg_err_o=1; reads unaffected; LOCK cleared only by reset.
REQ-016 SHALL write CTRL with LOCK as sticky-set (writing 0 to bit0 does not clear it); unused bits read 0.
REQ-017 SHALL error (cfg_err_o=1, no update) on writes to unmapped words.
REQ-018 SHALL treat rule i as hit when RULE_EN[i]=1 and START[i] <= addr < END[i], unsigned, full AddrWidth compare.
REQ-019 SHALL never hit a rule with END[i] <= START[i].
REQ-020 SHALL select the lowest-index hitting rule on multiple hits: res_hit_o=1, res_idx_o=i, res_decerr_o=0.
REQ-021 SHALL, on no hit with DEF_EN=1, output res_idx_o=DEF_IDX, res_hit_o=0, res_decerr_o=0.
REQ-022 SHALL, on no hit with DEF_EN=0, output res_idx_o=0, res_hit_o=0, res_decerr_o=1.
REQ-023 SHALL be a one-entry output register: lk_ready_o = !res_valid_o || res_ready_i.
REQ-024 SHALL capture a result at the edge where lk_valid_i && lk_ready_o; latency one cycle.
REQ-025 SHALL hold res_* stable while res_valid_o && !res_ready_i.
REQ-026 SHALL support full throughput: back-to-back lookups with res_ready_i=1 produce one result per cycle.
REQ-027 SHALL decode a lookup with register values as of the capture edge (a same-cycle config write does not affect it).
REQ-028 SHALL clear res_valid_o when res_ready_i=1 and no new lookup is accepted.

Reset
REQ-029 SHALL, on rst_ni=0, asynchronously set START/END to ResetStart/ResetEnd, RULE_EN to all-ones (NumRules bits), CTRL=0, DEF_IDX=0.
REQ-030 SHALL, on reset, drive res_valid_o=0, res_idx_o=0, res_hit_o=0, res_decerr_o=0, cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0.
REQ-031 SHALL discard any in-flight lookup result and config response when reset asserts mid-operation.

Verification
REQ-032 Rules 0:[0x1000,0x2000), 1:[0x1800,0x3000); lookup 0x1800 -> next cycle res_hit_o=1, res_idx_o=0.
REQ-033 Lookup 0x2FFF -> idx 1 hit; lookup 0x3000 with DEF_EN=0 -> res_decerr_o=1; with DEF_EN=1, DEF_IDX=13 -> idx 13, hit 0.
REQ-034 Write CTRL=1 then write START[0]=0x5000 -> cfg_err_o=1, read-back of word 4 still 0x1000; write CTRL=0 -> LOCK stays 1.
REQ-035 Hold res_ready_i=0 for 3 cycles after lookup -> res_* stable, lk_ready_o=0; release -> next lookup accepted same cycle.
REQ-036 Write END[0]=0x1000 (== START) in same cycle as lookup 0x1800 -> that lookup hits rule 0; next lookup 0x1800 -> hits rule 1.
REQ-037 Assert rst_ni=0 while res_valid_o=1 and LOCK=1 -> res_valid_o=0 immediately; after release registers equal reset values, LOCK=0.
